// File: rtl/mult32x32_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mult32x32_fsm
// Purpose  : Sequencing controller for the 32x32 multiplier datapath. On a
//            start request it walks the datapath through eight partial-product
//            steps (4 bytes of a x 2 halfwords of b), driving the operand
//            selects, the partial-product shift and the product-register
//            clear/accumulate strobes.
// Options  : MULT_FSM_DONE_EN - adds a registered one-cycle 'done' pulse in
//            the IDLE cycle that follows the last step.
// Revision : 1.0 - initial release
// ============================================================================
module mult32x32_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic [1:0] a_sel,
    output logic       b_sel,
    output logic [2:0] shift_sel,
    output logic       upd_prod,
    output logic       clr_prod
`ifdef MULT_FSM_DONE_EN
    ,
    output logic       done
`endif
);

    // IDLE plus one state per partial-product step. Encodings 9..15 are
    // unreachable and fall back to IDLE.
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_S0   = 4'd1,
        ST_S1   = 4'd2,
        ST_S2   = 4'd3,
        ST_S3   = 4'd4,
        ST_S4   = 4'd5,
        ST_S5   = 4'd6,
        ST_S6   = 4'd7,
        ST_S7   = 4'd8
    } state_t;

    state_t     state_q;
    state_t     state_d;

    // Moore outputs are held in flops loaded from the next-state decode, so
    // they change only at the clock edge together with the state and stay
    // glitch-free for the whole step cycle.
    logic       busy_q;
    logic       busy_d;
    logic [1:0] a_sel_q;
    logic [1:0] a_sel_d;
    logic       b_sel_q;
    logic       b_sel_d;
    logic [2:0] shift_sel_q;
    logic [2:0] shift_sel_d;
    logic       upd_prod_q;
    logic       upd_prod_d;

    // Next-state logic: start is only honoured in IDLE, steps advance unconditionally.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = start ? ST_S0 : ST_IDLE;
            ST_S0:   state_d = ST_S1;
            ST_S1:   state_d = ST_S2;
            ST_S2:   state_d = ST_S3;
            ST_S3:   state_d = ST_S4;
            ST_S4:   state_d = ST_S5;
            ST_S5:   state_d = ST_S6;
            ST_S6:   state_d = ST_S7;
            ST_S7:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Step table: a_sel = k mod 4, b_sel = k div 4, shift = a_sel + 2*b_sel.
    always_comb begin
        busy_d      = 1'b1;
        upd_prod_d  = 1'b1;
        a_sel_d     = 2'd0;
        b_sel_d     = 1'b0;
        shift_sel_d = 3'd0;
        case (state_d)
            ST_S0: begin a_sel_d = 2'd0; b_sel_d = 1'b0; shift_sel_d = 3'd0; end
            ST_S1: begin a_sel_d = 2'd1; b_sel_d = 1'b0; shift_sel_d = 3'd1; end
            ST_S2: begin a_sel_d = 2'd2; b_sel_d = 1'b0; shift_sel_d = 3'd2; end
            ST_S3: begin a_sel_d = 2'd3; b_sel_d = 1'b0; shift_sel_d = 3'd3; end
            ST_S4: begin a_sel_d = 2'd0; b_sel_d = 1'b1; shift_sel_d = 3'd2; end
            ST_S5: begin a_sel_d = 2'd1; b_sel_d = 1'b1; shift_sel_d = 3'd3; end
            ST_S6: begin a_sel_d = 2'd2; b_sel_d = 1'b1; shift_sel_d = 3'd4; end
            ST_S7: begin a_sel_d = 2'd3; b_sel_d = 1'b1; shift_sel_d = 3'd5; end
            default: begin
                busy_d     = 1'b0;
                upd_prod_d = 1'b0;
            end
        endcase
    end

    // State and Moore output registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            a_sel_q     <= 2'd0;
            b_sel_q     <= 1'b0;
            shift_sel_q <= 3'd0;
            upd_prod_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            a_sel_q     <= a_sel_d;
            b_sel_q     <= b_sel_d;
            shift_sel_q <= shift_sel_d;
            upd_prod_q  <= upd_prod_d;
        end
    end

    assign busy      = busy_q;
    assign a_sel     = a_sel_q;
    assign b_sel     = b_sel_q;
    assign shift_sel = shift_sel_q;
    assign upd_prod  = upd_prod_q;

    // Clear is Mealy so the product register empties on the very edge that
    // accepts start; it is masked by reset because reset dominates start.
    assign clr_prod = (state_q == ST_IDLE) && start && !reset;

`ifdef MULT_FSM_DONE_EN
    logic done_q;

    // Completion pulse: high in the IDLE cycle right after the final step.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == ST_S7);
        end
    end

    assign done = done_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult32x32_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult32x32_fsm
// Purpose  : Self-checking bench for mult32x32_fsm. A cycle-level reference
//            model tracks which step the controller should be in and queues
//            the arithmetic product a*b of every accepted operation; a
//            monitor checks all outputs every cycle and, on each busy falling
//            edge, compares the product built by a behavioural datapath that
//            follows the DUT's controls against the queued value.
//            Build with MULT_FSM_DONE_EN defined to also check 'done'.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult32x32_fsm;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
        bit          aborted;
    } op_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [2:0]  shift_sel;
    logic        upd_prod;
    logic        clr_prod;
    logic        dut_done;
    logic [31:0] op_a;
    logic [31:0] op_b;

    int          checks = 0;
    int          errors = 0;
    int          phase  = -1;     // -1 = idle, 0..7 = step being executed
    bit          done_m = 1'b0;
    op_t         exp_q[$];
    logic [63:0] prod_m = 64'd0;
    int          run_len = 0;
    bit          busy_prev = 1'b0;

    mult32x32_fsm u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .shift_sel (shift_sel),
        .upd_prod  (upd_prod),
`ifdef MULT_FSM_DONE_EN
        .clr_prod  (clr_prod),
        .done      (dut_done)
`else
        .clr_prod  (clr_prod)
`endif
    );

`ifndef MULT_FSM_DONE_EN
    assign dut_done = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: advance the expected step and queue the product of
    // every operation that is accepted.
    always @(posedge clk) begin : ref_model
        done_m = !reset && (phase == 7);
        if (reset) begin
            if (phase >= 0 && exp_q.size() > 0) exp_q[exp_q.size()-1].aborted = 1'b1;
            phase = -1;
        end else if (phase < 0) begin
            if (start) begin
                exp_q.push_back('{op_a, op_b, 64'(op_a) * 64'(op_b), 1'b0});
                phase = 0;
            end
        end else if (phase == 7) begin
            phase = -1;
        end else begin
            phase = phase + 1;
        end
    end

    // Monitor: per-cycle output check, product scoreboard, behavioural datapath.
    always @(negedge clk) begin : monitor
        logic [9:0]  act_v;
        logic [9:0]  exp_v;
        logic        e_busy;
        logic [1:0]  e_a;
        logic        e_b;
        logic [2:0]  e_sh;
        logic        e_done;
        logic [7:0]  a_byte;
        logic [15:0] b_half;
        op_t         e;

        e_busy = (phase >= 0);
        e_a    = e_busy ? 2'(phase % 4) : 2'd0;
        e_b    = e_busy ? 1'(phase / 4) : 1'b0;
        e_sh   = 3'(e_a) + 3'(2 * e_b);
`ifdef MULT_FSM_DONE_EN
        e_done = done_m;
`else
        e_done = 1'b0;
`endif
        exp_v = {e_busy, e_a, e_b, e_sh, e_busy, (phase < 0) && start && !reset, e_done};
        act_v = {busy, a_sel, b_sel, shift_sel, upd_prod, clr_prod, dut_done};
        check("outputs{busy,a,b,sh,upd,clr,done}", 64'(act_v), 64'(exp_v));

        // Product is final in the first cycle busy reads low again.
        if (busy_prev && !busy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_busy_end", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                if (!e.aborted) begin
                    check("busy_len", 64'(run_len), 64'd8);
                    check("product", prod_m, e.prod);
                end
            end
        end
        run_len   = busy ? run_len + 1 : 0;
        busy_prev = busy;

        // Datapath: register updates at the coming edge from this cycle's controls.
        a_byte = 8'(op_a >> (8 * a_sel));
        b_half = b_sel ? op_b[31:16] : op_b[15:0];
        if (clr_prod === 1'b1)
            prod_m = 64'd0;
        else if (upd_prod === 1'b1)
            prod_m = prod_m + ((64'(a_byte) * 64'(b_half)) << (8 * shift_sel));
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(9);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op_a  = 32'd0;
        op_b  = 32'd0;
        cyc(2);
        reset = 1'b0;
        cyc(5);

        run_op(32'h0000_0002, 32'h0000_0003);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32'h1234_5678, 32'h9ABC_DEF0);

        // start asserted again during S3 must be ignored
        op_a = 32'hDEAD_BEEF; op_b = 32'hCAFE_F00D;
        start = 1'b1; cyc(1);
        start = 1'b0; cyc(3);
        start = 1'b1; cyc(1);
        start = 1'b0; cyc(8);

        // reset during S5 abandons the operation; a following start restarts
        op_a = 32'h0F0F_0F0F; op_b = 32'h0000_FFFF;
        start = 1'b1; cyc(1);
        start = 1'b0; cyc(5);
        reset = 1'b1; cyc(1);
        reset = 1'b0; cyc(1);
        op_a = 32'h0000_0101; op_b = 32'h8000_0001;
        start = 1'b1; cyc(1);
        start = 1'b0; cyc(9);

        // start held high: back-to-back operations, 9-cycle period
        op_a = 32'h7654_3210; op_b = 32'hFEDC_BA98;
        start = 1'b1; cyc(20);
        start = 1'b0; cyc(10);

        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if (phase < 0) begin
                case ($urandom % 4)
                    0:       begin op_a = 32'hFFFF_FFFF; op_b = $urandom; end
                    1:       begin op_a = $urandom; op_b = 32'd0; end
                    default: begin op_a = $urandom; op_b = $urandom; end
                endcase
            end
            start = ($urandom % 3 == 0);
            reset = ($urandom % 60 == 0);
            cyc(1);
        end
        start = 1'b0;
        reset = 1'b0;
        cyc(12);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
